and_gate_bist_ctrl: RTL and testbench

Self-test sequencer for the 2-input and_gate datapath. On a start pulse it drives the gate inputs through the full truth table (00, 01, 10, 11) and waits a programmable settle time per vector. It then samples the gate output, compares it with the expected AND result, and reports a per-vector fail mask plus an overall pass/done status. It sits beside the gate, and bring-up logic or a top-level test harness triggers it.

---
 rtl/and_bist_pkg.sv | 26 ++
 rtl/and_gate_bist_ctrl_settle_timer.sv | 29 ++
 rtl/and_gate_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_and_gate_bist_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/and_bist_pkg.sv
// Shared types and helpers for the and_gate self-test controller.
// Build option: AND_BIST_ABORT_ON_FAIL_EN (consumed by and_gate_bist_ctrl).
package and_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } bist_state_e;

    localparam int unsigned VEC_W   = 2;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Expected gate output for vector {A,B} = vi.
    function automatic logic exp_and(input logic [VEC_W-1:0] vi);
        return vi[1] & vi[0];
    endfunction

endpackage

// File: rtl/and_gate_bist_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag; times the per-vector settle window.
// Build option: none (AND_BIST_ABORT_ON_FAIL_EN does not affect this block).
module bist_settle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/and_gate_bist_ctrl.sv
// Self-test sequencer for the 2-input and_gate: sweeps {A,B} through 00..11,
// waits SETTLE_CYCLES per vector, checks C, and reports fail mask / error
// count / pass with a one-cycle done pulse.
// Build option: AND_BIST_ABORT_ON_FAIL_EN -- when defined, the first mismatch
// ends the sequence immediately.
module and_gate_bist_ctrl
    import and_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [3:0] err_count
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_PASS   = 4'(NUM_PASSES - 1);

    bist_state_e        state_q, state_d;
    logic [VEC_W-1:0]   vi_q, vi_d;
    logic [3:0]         pc_q, pc_d;
    logic [VEC_W-1:0]   gate_q, gate_d;
    logic [NUM_VEC-1:0] mask_q, mask_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;

    logic tmr_load, tmr_dec, tmr_zero;
    logic mismatch, finish;

    bist_settle_timer #(
        .WIDTH (CNT_W)
    ) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // State and result registers; reset aborts any sweep with no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vi_q    <= '0;
            pc_q    <= '0;
            gate_q  <= '0;
            mask_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vi_q    <= vi_d;
            pc_q    <= pc_d;
            gate_q  <= gate_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic: sweep vectors, accumulate mismatches, decide when to stop.
    always_comb begin
        state_d  = state_q;
        vi_d     = vi_q;
        pc_d     = pc_q;
        gate_d   = gate_q;
        mask_d   = mask_q;
        err_d    = err_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        // X/Z on C must count as a failure, hence the case inequality.
        mismatch = (gate_c !== exp_and(vi_q));
        finish   = (vi_q == LAST_VEC) && (pc_q >= LAST_PASS);
`ifdef AND_BIST_ABORT_ON_FAIL_EN
        finish   = finish | mismatch;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vi_d    = '0;
                    pc_d    = '0;
                    mask_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                gate_d   = vi_q;
                tmr_load = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    mask_d[vi_q] = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end
                // pass looks at mask_d so the final CHECK's result is included.
                if (finish) begin
                    state_d = DONE;
                    pass_d  = (mask_d == '0);
                    gate_d  = '0;
                end else if (vi_q != LAST_VEC) begin
                    vi_d    = vi_q + 1'b1;
                    state_d = DRIVE;
                end else begin
                    vi_d    = '0;
                    pc_d    = pc_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gate_a    = gate_q[1];
    assign gate_b    = gate_q[0];
    assign busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_and_gate_bist_ctrl.sv
// Self-checking bench for and_gate_bist_ctrl: two instances (1 and 2 passes),
// a behavioural gate with a programmable truth table, a vector table and
// randomized runs checked against a sweep-level reference model.
// Build option: AND_BIST_ABORT_ON_FAIL_EN changes the expected results.
module tb_and_gate_bist_ctrl;

    localparam int unsigned S   = 2;
    localparam int          NP1 = 1;
    localparam int          NP2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start2;
    logic [3:0] truth1, truth2;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic       a2, b2, c2, busy2, done2, pass2;
    logic [3:0] fm1, ec1, fm2, ec2;

    // Behavioural gate under test: C = truth[{A,B}].
    assign c1 = truth1[{a1, b1}];
    assign c2 = truth2[{a2, b2}];

    and_gate_bist_ctrl #(
        .SETTLE_CYCLES (S),
        .NUM_PASSES    (NP1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .gate_a    (a1),
        .gate_b    (b1),
        .gate_c    (c1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .fail_mask (fm1),
        .err_count (ec1)
    );

    and_gate_bist_ctrl #(
        .SETTLE_CYCLES (S),
        .NUM_PASSES    (NP2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .gate_a    (a2),
        .gate_b    (b2),
        .gate_c    (c2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .fail_mask (fm2),
        .err_count (ec2)
    );

    int         sel;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [3:0] fm_s, ec_s;

    always_comb begin
        a_s    = (sel != 0) ? a2    : a1;
        b_s    = (sel != 0) ? b2    : b1;
        busy_s = (sel != 0) ? busy2 : busy1;
        done_s = (sel != 0) ? done2 : done1;
        pass_s = (sel != 0) ? pass2 : pass1;
        fm_s   = (sel != 0) ? fm2   : fm1;
        ec_s   = (sel != 0) ? ec2   : ec1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start1 = v;
        else        start2 = v;
    endtask

    // Sweep-level reference: each vector's mismatch is a truth-table compare.
    function automatic void model(input logic [3:0] t, input int np,
                                  output logic [3:0] m, output logic [3:0] e,
                                  output logic p, output int lat);
        int bad;
        bad = 0;
        m   = '0;
        for (int i = 0; i < 4; i++) begin
            if (t[i] != (i == 3)) begin
                m[i] = 1'b1;
                bad++;
            end
        end
        e   = (np * bad > 15) ? 4'd15 : 4'(np * bad);
        lat = 1 + np * 4 * (int'(S) + 2);
`ifdef AND_BIST_ABORT_ON_FAIL_EN
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                m   = 4'b0001 << i;
                e   = 4'd1;
                lat = 1 + (i + 1) * (int'(S) + 2);
                break;
            end
        end
`endif
        p = (m == '0);
    endfunction

    // Expected {A,B} in busy cycle k (k=1 is the first cycle after start).
    function automatic logic [1:0] exp_gate(input int k);
        int p, slot, off;
        p    = k - 1;
        slot = p / (int'(S) + 2);
        off  = p % (int'(S) + 2);
        if (off == 0) return (slot == 0) ? 2'b00 : 2'((slot - 1) % 4);
        return 2'(slot % 4);
    endfunction

    // One full start..done..idle sequence on instance s; entered and left at a negedge.
    task automatic run_seq(input int s, input logic [3:0] truth, input bit repulse,
                           input bit drop, input logic [3:0] em, input logic [3:0] ee,
                           input logic ep, input int el);
        int n;
        bit seen, gate_bad, busy_bad;
        sel = s;
        if (s == 0) truth1 = truth;
        else        truth2 = truth;
        set_start(s, 1'b1);
        n = 0; seen = 0; gate_bad = 0; busy_bad = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            set_start(s, repulse && (n == 3 || n == 7));
            if (done_s) begin
                seen = 1;
            end else begin
                if (busy_s !== 1'b1) busy_bad = 1;
                if ({a_s, b_s} !== exp_gate(n)) gate_bad = 1;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(n), 32'(el));
        chk("busy_span", 32'(busy_bad), 32'd0);
        chk("gate_seq", 32'(gate_bad), 32'd0);
        chk("busy_in_done", 32'(busy_s), 32'd0);
        chk("fail_mask", 32'(fm_s), 32'(em));
        chk("err_count", 32'(ec_s), 32'(ee));
        chk("pass", 32'(pass_s), 32'(ep));
        if (drop) set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk("done_one_cycle", 32'(done_s), 32'd0);
        chk("idle_not_busy", 32'(busy_s), 32'd0);
        chk("idle_gates", 32'({a_s, b_s}), 32'd0);
        chk("pass_held", 32'(pass_s), 32'(ep));
        chk("mask_held", 32'(fm_s), 32'(em));
    endtask

    typedef struct {
        int         sel;
        logic [3:0] truth;
        bit         repulse;
        bit         drop;
        logic [3:0] mask;
        logic [3:0] err;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [3:0] m, e;
        logic       p;
        int         lat, s, gap;
        logic [3:0] t;

`ifdef AND_BIST_ABORT_ON_FAIL_EN
        tbl[0] = '{0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1, 17};
        tbl[1] = '{0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'd1, 1'b0, 17};
        tbl[2] = '{1, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b0, 5};
        tbl[3] = '{0, 4'b1000, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b1, 17};
        tbl[4] = '{0, 4'b0110, 1'b0, 1'b1, 4'b0010, 4'd1, 1'b0, 9};
        tbl[5] = '{1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'd1, 1'b0, 17};
        tbl[6] = '{0, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b0, 5};
`else
        tbl[0] = '{0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1, 17};
        tbl[1] = '{0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'd1, 1'b0, 17};
        tbl[2] = '{1, 4'b1111, 1'b0, 1'b0, 4'b0111, 4'd6, 1'b0, 33};
        tbl[3] = '{0, 4'b1000, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b1, 17};
        tbl[4] = '{0, 4'b0110, 1'b0, 1'b1, 4'b1110, 4'd3, 1'b0, 17};
        tbl[5] = '{1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'd2, 1'b0, 33};
        tbl[6] = '{0, 4'b1111, 1'b0, 1'b0, 4'b0111, 4'd3, 1'b0, 17};
`endif

        sel = 0;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        truth1 = 4'b1000; truth2 = 4'b1000;
        repeat (3) @(negedge clk);
        chk("reset_outs_dut1", 32'({a1, b1, busy1, done1, pass1, fm1, ec1}), 32'd0);
        chk("reset_outs_dut2", 32'({a2, b2, busy2, done2, pass2, fm2, ec2}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_seq(tbl[i].sel, tbl[i].truth, tbl[i].repulse, tbl[i].drop,
                    tbl[i].mask, tbl[i].err, tbl[i].pass, tbl[i].lat);
        end

        // Reset during SETTLE of vector 2: outputs clear at once, no done follows.
        begin
            bit done_bad;
            sel = 0;
            truth1 = 4'b1000;
            start1 = 1'b1;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                start1 = 1'b0;
            end
            chk("pre_reset_gates", 32'({a1, b1}), 32'b10);
            chk("pre_reset_busy", 32'(busy1), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("async_reset_outs", 32'({a1, b1, busy1, done1, pass1, fm1, ec1}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            done_bad = 0;
            for (int n = 0; n < 25; n++) begin
                @(negedge clk);
                if (done1 || busy1) done_bad = 1;
            end
            chk("no_done_after_reset", 32'(done_bad), 32'd0);
            run_seq(0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1, 17);
        end

        // Randomized truth tables, gaps, re-pulses and dropped starts.
        for (int r = 0; r < 24; r++) begin
            s   = int'($urandom_range(0, 1));
            t   = 4'($urandom);
            gap = int'($urandom_range(0, 3));
            model(t, (s == 0) ? NP1 : NP2, m, e, p, lat);
            repeat (gap) @(negedge clk);
            run_seq(s, t, 1'($urandom), 1'($urandom), m, e, p, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
